// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the single-port RAM controller slice:
//   - state_e : controller FSM states (CLEAR sweep, IDLE service)
//   - DEF_*   : default parameter values used by the top level
package ram_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W          = 4;
  localparam int DEF_ADDR_W          = 5;
  localparam int DEF_INIT_VAL        = 0;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Synchronises a raw active-low key, debounces it and emits a one-cycle pulse
// on each accepted press (debounced 1->0 transition).
// Ports:
//   clk      in  1  clock
//   rst_n    in  1  asynchronous active-low reset
//   key_n    in  1  raw active-low key, asynchronous and bouncy
//   wr_pulse out 1  registered one-cycle pulse per accepted press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic wr_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;

  // Stable-sample counter: counts consecutive samples that disagree with the
  // debounced level; the DEBOUNCE_CYCLES-th such sample flips the level.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, debounce state and falling-edge pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= deb_q & ~deb_d;
    end
  end

  assign wr_pulse = pulse_q;

endmodule

// File: rtl/ram_sp_core.sv
// ram_sp_core
// Inferred single-port synchronous RAM with a registered, write-first read port.
// Ports:
//   clk  in  1       clock
//   we   in  1       write enable
//   addr in  ADDR_W  read/write address
//   din  in  DATA_W  write data
//   dout out DATA_W  registered read data (shows din on a write cycle)
module ram_sp_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  // Array write and write-first registered read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
      dout_q      <= din;
    end else begin
      dout_q      <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl
// Single-port RAM with controller: debounced key write, clear sweep after
// reset or on request, busy and write-acknowledge status.
// Ports:
//   FPGA_CLK1_50 in  1       clock
//   reset_n      in  1       asynchronous active-low reset
//   addr         in  ADDR_W  read/write address
//   wr_data      in  DATA_W  write data
//   key_wr_n     in  1       raw active-low write key
//   clr_req      in  1       single-cycle clear sweep request
//   rd_data      out DATA_W  read data, one cycle after addr
//   busy         out 1       clear sweep in progress
//   wr_ack       out 1       one-cycle pulse per committed key write
module ram_sp_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int                DATA_W          = DEF_DATA_W,
  parameter int                ADDR_W          = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL        = DATA_W'(DEF_INIT_VAL),
  parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              FPGA_CLK1_50,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              key_wr_n,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              wr_ack
);

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              busy_q;
  logic              busy_d;
  logic              ack_q;
  logic              ack_d;
  logic              rd_live_q;
  logic              rd_live_d;
  logic [DATA_W-1:0] rd_hold_q;

  logic              wr_pulse_s;
  logic              core_we_s;
  logic [ADDR_W-1:0] core_addr_s;
  logic [DATA_W-1:0] core_din_s;
  logic [DATA_W-1:0] core_dout_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk     (FPGA_CLK1_50),
    .rst_n   (reset_n),
    .key_n   (key_wr_n),
    .wr_pulse(wr_pulse_s)
  );

  ram_sp_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk (FPGA_CLK1_50),
    .we  (core_we_s),
    .addr(core_addr_s),
    .din (core_din_s),
    .dout(core_dout_s)
  );

  // Next-state logic and RAM port mux; a clear request beats a same-cycle key write.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    core_we_s   = 1'b0;
    core_addr_s = addr;
    core_din_s  = wr_data;
    case (state_q)
      CLEAR: begin
        core_we_s   = 1'b1;
        core_addr_s = cnt_q;
        core_din_s  = INIT_VAL;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
        end else if (wr_pulse_s) begin
          core_we_s = 1'b1;
          ack_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
    busy_d    = (state_d == CLEAR);
    // The core's output register only carries a real read when the FSM was idle.
    rd_live_d = (state_q == IDLE);
  end

  // Controller state, status and read-hold registers.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      rd_live_q <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      rd_live_q <= rd_live_d;
      rd_hold_q <= rd_data;
    end
  end

  // During a sweep (and after reset) the last visible read value is frozen.
  assign rd_data = rd_live_q ? core_dout_s : rd_hold_q;
  assign busy    = busy_q;
  assign wr_ack  = ack_q;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
module tb_ram_sp_ctrl;

  logic       FPGA_CLK1_50;
  logic       reset_n;
  logic [4:0] addr;
  logic [3:0] wr_data;
  logic       key_wr_n;
  logic       clr_req;
  logic [3:0] rd_data;
  logic       busy;
  logic       wr_ack;

  int vec_cnt;
  int err_cnt;
  int ack_total;
  int overlap_cnt;

  ram_sp_ctrl #(
    .DATA_W         (4),
    .ADDR_W         (5),
    .INIT_VAL       (4'hA),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .FPGA_CLK1_50(FPGA_CLK1_50),
    .reset_n     (reset_n),
    .addr        (addr),
    .wr_data     (wr_data),
    .key_wr_n    (key_wr_n),
    .clr_req     (clr_req),
    .rd_data     (rd_data),
    .busy        (busy),
    .wr_ack      (wr_ack)
  );

  initial FPGA_CLK1_50 = 1'b0;
  always #5 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  // Count acknowledges and any cycle where ack and busy coincide.
  always @(posedge FPGA_CLK1_50) begin
    if (wr_ack === 1'b1) ack_total <= ack_total + 1;
    if (wr_ack === 1'b1 && busy === 1'b1) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic tick();
    @(posedge FPGA_CLK1_50);
    #1;
  endtask

  task automatic test_reset();
    int n;
    #3;
    vec_cnt++;
    if (rd_data !== 4'h0 || busy !== 1'b1 || wr_ack !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state rd=%h busy=%b ack=%b want rd=0 busy=1 ack=0", rd_data, busy, wr_ack);
    end
    @(negedge FPGA_CLK1_50);
    reset_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n != 32) begin
      err_cnt++;
      $display("FAIL init_sweep_len got %0d cycles want 32", n);
    end
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      tick();
      vec_cnt++;
      if (rd_data !== 4'hA) begin
        err_cnt++;
        $display("FAIL init_read addr=%0d got %h want a", a, rd_data);
      end
    end
  endtask

  task automatic test_clean_write();
    int a0;
    int seen;
    a0 = ack_total;
    seen = 0;
    addr = 5'd3;
    wr_data = 4'h5;
    key_wr_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_ack === 1'b1) begin
        seen++;
        vec_cnt++;
        if (rd_data !== 4'h5) begin
          err_cnt++;
          $display("FAIL clean_ack_data got %h want 5", rd_data);
        end
      end
    end
    key_wr_n = 1'b1;
    repeat (15) tick();
    vec_cnt++;
    if (ack_total - a0 != 1 || seen != 1) begin
      err_cnt++;
      $display("FAIL clean_ack_count got %0d want 1", ack_total - a0);
    end
    addr = 5'd4;
    tick();
    vec_cnt++;
    if (rd_data !== 4'hA) begin
      err_cnt++;
      $display("FAIL clean_neighbour got %h want a", rd_data);
    end
    addr = 5'd3;
    tick();
    vec_cnt++;
    if (rd_data !== 4'h5) begin
      err_cnt++;
      $display("FAIL clean_readback got %h want 5", rd_data);
    end
  endtask

  task automatic test_bouncy_write();
    int a0;
    a0 = ack_total;
    addr = 5'd7;
    wr_data = 4'hC;
    for (int p = 0; p < 5; p++) begin
      key_wr_n = p[0];
      repeat (2) tick();
    end
    key_wr_n = 1'b0;
    repeat (20) tick();
    key_wr_n = 1'b1;
    repeat (15) tick();
    vec_cnt++;
    if (ack_total - a0 != 1) begin
      err_cnt++;
      $display("FAIL bouncy_ack_count got %0d want 1", ack_total - a0);
    end
    addr = 5'd7;
    tick();
    vec_cnt++;
    if (rd_data !== 4'hC) begin
      err_cnt++;
      $display("FAIL bouncy_readback got %h want c", rd_data);
    end
  endtask

  task automatic test_clear_mid_sweep_press();
    int a0;
    int n;
    a0 = ack_total;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL clr_busy_rise got %b want 1", busy);
    end
    addr = 5'd11;
    wr_data = 4'h3;
    key_wr_n = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n != 32) begin
      err_cnt++;
      $display("FAIL clr_sweep_len got %0d cycles want 32", n);
    end
    key_wr_n = 1'b1;
    repeat (15) tick();
    vec_cnt++;
    if (ack_total - a0 != 0) begin
      err_cnt++;
      $display("FAIL clr_press_ack got %0d acks want 0", ack_total - a0);
    end
    addr = 5'd11;
    tick();
    vec_cnt++;
    if (rd_data !== 4'hA) begin
      err_cnt++;
      $display("FAIL clr_press_addr got %h want a", rd_data);
    end
    addr = 5'd3;
    tick();
    vec_cnt++;
    if (rd_data !== 4'hA) begin
      err_cnt++;
      $display("FAIL clr_addr3 got %h want a", rd_data);
    end
  endtask

  task automatic test_clr_with_pulse();
    int a0;
    int n;
    a0 = ack_total;
    addr = 5'd9;
    wr_data = 4'h1;
    key_wr_n = 1'b0;
    // Sync (2) + debounce (4) edges: the press pulse is live after the 6th edge.
    repeat (6) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1 || wr_ack !== 1'b0) begin
      err_cnt++;
      $display("FAIL race_state busy=%b ack=%b want busy=1 ack=0", busy, wr_ack);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    key_wr_n = 1'b1;
    repeat (15) tick();
    vec_cnt++;
    if (ack_total - a0 != 0) begin
      err_cnt++;
      $display("FAIL race_ack got %0d acks want 0", ack_total - a0);
    end
    addr = 5'd9;
    tick();
    vec_cnt++;
    if (rd_data !== 4'hA) begin
      err_cnt++;
      $display("FAIL race_addr9 got %h want a", rd_data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (rd_data !== 4'h0 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL midreset_state rd=%h busy=%b want rd=0 busy=1", rd_data, busy);
    end
    @(negedge FPGA_CLK1_50);
    reset_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n != 32) begin
      err_cnt++;
      $display("FAIL midreset_sweep_len got %0d cycles want 32", n);
    end
    addr = 5'd31;
    tick();
    vec_cnt++;
    if (rd_data !== 4'hA) begin
      err_cnt++;
      $display("FAIL midreset_read31 got %h want a", rd_data);
    end
    vec_cnt++;
    if (overlap_cnt != 0) begin
      err_cnt++;
      $display("FAIL ack_busy_overlap got %0d cycles want 0", overlap_cnt);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    ack_total = 0;
    overlap_cnt = 0;
    reset_n = 1'b1;
    addr = 5'd0;
    wr_data = 4'h0;
    key_wr_n = 1'b1;
    clr_req = 1'b0;
    #2;
    reset_n = 1'b0;
    test_reset();
    test_clean_write();
    test_bouncy_write();
    test_clear_mid_sweep_press();
    test_clr_with_pulse();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
